// File: rtl/addsub_pipe_if.sv
// addsub_pipe_if: operand/result handshake bundle for addsub_pipe.
// master drives operands and OutReady; slave (the adder) drives InReady and results.
interface addsub_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] In1;
    logic [WIDTH-1:0] In2;
    logic             Sub;
    logic             Cin;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Sum;
    logic             Cout;
    logic             Overflow;
    logic             Zero;

    modport master (
        output InValid, In1, In2, Sub, Cin, OutReady,
        input  InReady, OutValid, Sum, Cout, Overflow, Zero
    );

    modport slave (
        input  InValid, In1, In2, Sub, Cin, OutReady,
        output InReady, OutValid, Sum, Cout, Overflow, Zero
    );
endinterface

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined two's-complement adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES slices of WIDTH/STAGES bits with a register after each
// slice; operands are skewed in and partial sums accumulate so the result emerges aligned.
// WIDTH must be a multiple of STAGES. Latency is STAGES cycles; throughput one op per cycle.
// Optional feature: define ADDSUB_PIPE_SAT_EN to clamp Sum on signed overflow (flags stay raw).
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input logic          Clk,
    input logic          Rst_n,
    addsub_pipe_if.slave bus
);
    localparam int unsigned SW = WIDTH / STAGES;

    logic             advance;
    logic             accept;
    logic [WIDTH-1:0] b_eff;

    // Inputs to the final slice, taken from the last pipe stage or straight from the bus
    logic [SW-1:0]    la;
    logic [SW-1:0]    lb;
    logic             lc;
    logic             lz;
    logic             lv;
    logic [SW:0]      last_slice;
    logic [WIDTH-1:0] raw_sum;

    logic             msb_carry_in;
    logic             ovf_d;
    logic             zero_d;
    logic [WIDTH-1:0] sum_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Whole pipe shifts together unless a finished result is waiting on the consumer
    always_comb begin
        advance = ~out_valid_q | bus.OutReady;
        accept  = bus.InValid & advance;
        b_eff   = bus.Sub ? ~bus.In2 : bus.In2;
    end

    // Stage k adds slice k and keeps the not-yet-used operand bits plus the low result bits
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_stage
        localparam int unsigned IW = WIDTH - k * SW;

        logic [IW-1:0]         a_in;
        logic [IW-1:0]         b_in;
        logic                  c_in;
        logic                  z_in;
        logic                  v_in;
        logic [SW:0]           slice;
        logic [(k+1)*SW-1:0]   s_d;

        logic [IW-SW-1:0]      a_q;
        logic [IW-SW-1:0]      b_q;
        logic [(k+1)*SW-1:0]   s_q;
        logic                  c_q;
        logic                  z_q;
        logic                  v_q;

        if (k == 0) begin : g_head
            assign a_in = bus.In1;
            assign b_in = b_eff;
            assign c_in = bus.Cin;
            assign z_in = 1'b1;
            assign v_in = accept;
            assign s_d  = slice[SW-1:0];
        end else begin : g_body
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].b_q;
            assign c_in = g_stage[k-1].c_q;
            assign z_in = g_stage[k-1].z_q;
            assign v_in = g_stage[k-1].v_q;
            assign s_d  = {slice[SW-1:0], g_stage[k-1].s_q};
        end

        assign slice = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        // Valid bit: cleared by reset, shifts with the pipe (bubbles included)
        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                v_q <= 1'b0;
            end else if (advance) begin
                v_q <= v_in;
            end
        end

        // Operand skew, partial sum, slice carry and running zero flag
        always_ff @(posedge Clk) begin
            if (advance) begin
                a_q <= a_in[IW-1:SW];
                b_q <= b_in[IW-1:SW];
                s_q <= s_d;
                c_q <= slice[SW];
                z_q <= z_in & (slice[SW-1:0] == '0);
            end
        end
    end

    if (STAGES == 1) begin : g_single
        assign la      = bus.In1;
        assign lb      = b_eff;
        assign lc      = bus.Cin;
        assign lz      = 1'b1;
        assign lv      = accept;
        assign raw_sum = last_slice[SW-1:0];
    end else begin : g_multi
        assign la      = g_stage[STAGES-2].a_q;
        assign lb      = g_stage[STAGES-2].b_q;
        assign lc      = g_stage[STAGES-2].c_q;
        assign lz      = g_stage[STAGES-2].z_q;
        assign lv      = g_stage[STAGES-2].v_q;
        assign raw_sum = {last_slice[SW-1:0], g_stage[STAGES-2].s_q};
    end

    assign last_slice = {1'b0, la} + {1'b0, lb} + {{SW{1'b0}}, lc};

    // Final slice flags; la[SW-1] is the In1 sign bit carried through the skew registers
    always_comb begin
        msb_carry_in = la[SW-1] ^ lb[SW-1] ^ last_slice[SW-1];
        ovf_d        = msb_carry_in ^ last_slice[SW];
        zero_d       = lz & (last_slice[SW-1:0] == '0);
`ifdef ADDSUB_PIPE_SAT_EN
        if (ovf_d) begin
            sum_d = la[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            sum_d = raw_sum;
        end
`else
        sum_d = raw_sum;
`endif
    end

    // Output registers: cleared by reset, loaded on advance, held while stalled
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else if (advance) begin
            out_valid_q <= lv;
            sum_q       <= sum_d;
            cout_q      <= last_slice[SW];
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.InReady  = advance;
    assign bus.OutValid = out_valid_q;
    assign bus.Sum      = sum_q;
    assign bus.Cout     = cout_q;
    assign bus.Overflow = ovf_q;
    assign bus.Zero     = zero_q;
endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: scoreboard bench for addsub_pipe (32/4 directed + stall + reset, 8/1 random).
module tb_addsub_pipe;
    localparam int unsigned W_A = 32;
    localparam int unsigned S_A = 4;
    localparam int unsigned W_B = 8;
    localparam int unsigned S_B = 1;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    res_t sb_a[$];
    res_t sb_b[$];
    res_t held_a;
    logic hold_a = 1'b0;
    logic acc_a = 1'b0;
    logic acc_b = 1'b0;
    int   delivered_a = 0;

    addsub_pipe_if #(.WIDTH(W_A)) bus_a ();
    addsub_pipe_if #(.WIDTH(W_B)) bus_b ();

    addsub_pipe #(.WIDTH(W_A), .STAGES(S_A)) u_dut_a (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus_a)
    );

    addsub_pipe #(.WIDTH(W_B), .STAGES(S_B)) u_dut_b (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: add with inverted-operand subtract, flags from sign comparison
    function automatic res_t model(input int w, input logic [63:0] x, input logic [63:0] y,
                                   input logic sub, input logic cin);
        logic [63:0] mask, xx, yy, raw;
        logic [64:0] full;
        res_t r;
        mask   = (64'd1 << w) - 64'd1;
        xx     = x & mask;
        yy     = (sub ? ~y : y) & mask;
        full   = {1'b0, xx} + {1'b0, yy} + {64'd0, cin};
        raw    = full[63:0] & mask;
        r.cout = full[w];
        r.ovf  = (xx[w-1] == yy[w-1]) && (raw[w-1] != xx[w-1]);
        r.zero = (raw == 64'd0);
`ifdef ADDSUB_PIPE_SAT_EN
        if (r.ovf) raw = xx[w-1] ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
`endif
        r.sum  = raw[31:0];
        return r;
    endfunction

    // One cycle of DUT A: inputs already driven at the negedge; sample 1 time unit later
    task automatic cycle_a();
        res_t exp;
        #1;
        if (hold_a) begin
            check_eq("hold_valid", bus_a.OutValid, 1);
            check_eq("hold_sum", bus_a.Sum, held_a.sum);
            check_eq("hold_cout", bus_a.Cout, held_a.cout);
            check_eq("hold_ovf", bus_a.Overflow, held_a.ovf);
            check_eq("hold_zero", bus_a.Zero, held_a.zero);
        end
        check_eq("in_ready", bus_a.InReady, !(bus_a.OutValid && !bus_a.OutReady));
        if (bus_a.OutValid && bus_a.OutReady) begin
            check_eq("sb_pending", sb_a.size() != 0, 1);
            if (sb_a.size() != 0) begin
                exp = sb_a.pop_front();
                check_eq("sum", bus_a.Sum, exp.sum);
                check_eq("cout", bus_a.Cout, exp.cout);
                check_eq("overflow", bus_a.Overflow, exp.ovf);
                check_eq("zero", bus_a.Zero, exp.zero);
                delivered_a++;
            end
        end
        acc_a = rst_n && bus_a.InValid && bus_a.InReady;
        if (acc_a) sb_a.push_back(model(W_A, 64'(bus_a.In1), 64'(bus_a.In2), bus_a.Sub, bus_a.Cin));
        hold_a      = rst_n && bus_a.OutValid && !bus_a.OutReady;
        held_a.sum  = bus_a.Sum;
        held_a.cout = bus_a.Cout;
        held_a.ovf  = bus_a.Overflow;
        held_a.zero = bus_a.Zero;
        @(negedge clk);
    endtask

    // One cycle of DUT B (OutReady held high): result must follow acceptance by one cycle
    task automatic cycle_b();
        res_t exp;
        #1;
        check_eq("b_latency", bus_b.OutValid, acc_b);
        if (bus_b.OutValid) begin
            check_eq("b_sb_pending", sb_b.size() != 0, 1);
            if (sb_b.size() != 0) begin
                exp = sb_b.pop_front();
                check_eq("b_sum", bus_b.Sum, exp.sum);
                check_eq("b_cout", bus_b.Cout, exp.cout);
                check_eq("b_overflow", bus_b.Overflow, exp.ovf);
                check_eq("b_zero", bus_b.Zero, exp.zero);
            end
        end
        acc_b = rst_n && bus_b.InValid && bus_b.InReady;
        if (acc_b) sb_b.push_back(model(W_B, 64'(bus_b.In1), 64'(bus_b.In2), bus_b.Sub, bus_b.Cin));
        @(negedge clk);
    endtask

    // Single operation into an empty pipe; OutValid must rise exactly S_A cycles later
    task automatic run_iso(input logic [31:0] x, input logic [31:0] y, input logic sub,
                           input logic cin);
        bus_a.In1      = x;
        bus_a.In2      = y;
        bus_a.Sub      = sub;
        bus_a.Cin      = cin;
        bus_a.InValid  = 1'b1;
        bus_a.OutReady = 1'b1;
        cycle_a();
        check_eq("iso_accept", acc_a, 1);
        bus_a.InValid = 1'b0;
        for (int i = 1; i <= int'(S_A) + 2; i++) begin
            #1;
            check_eq("iso_latency", bus_a.OutValid, i == int'(S_A));
            cycle_a();
        end
        check_eq("iso_drain", sb_a.size(), 0);
    endtask

    initial begin
        int idx;
        int sent_b;
        rst_n          = 1'b0;
        bus_a.InValid  = 1'b0;
        bus_a.In1      = '0;
        bus_a.In2      = '0;
        bus_a.Sub      = 1'b0;
        bus_a.Cin      = 1'b0;
        bus_a.OutReady = 1'b1;
        bus_b.InValid  = 1'b0;
        bus_b.In1      = '0;
        bus_b.In2      = '0;
        bus_b.Sub      = 1'b0;
        bus_b.Cin      = 1'b0;
        bus_b.OutReady = 1'b1;
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        #1;
        check_eq("rst_out_valid", bus_a.OutValid, 0);
        check_eq("rst_in_ready", bus_a.InReady, 1);
        check_eq("rst_sum", bus_a.Sum, 0);
        check_eq("rst_cout", bus_a.Cout, 0);
        check_eq("rst_overflow", bus_a.Overflow, 0);
        check_eq("rst_zero", bus_a.Zero, 0);
        check_eq("rst_b_out_valid", bus_b.OutValid, 0);
        @(negedge clk);

        // Directed arithmetic corners
        run_iso(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_iso(32'd5, 32'd7, 1'b1, 1'b1);
        run_iso(32'd5, 32'd7, 1'b1, 1'b0);
        run_iso(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        run_iso(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_iso(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        run_iso(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);

        // Back-to-back with a consumer stall in cycles 5..8
        idx         = 0;
        delivered_a = 0;
        for (int cyc = 0; cyc < 40 && !(idx == 8 && sb_a.size() == 0); cyc++) begin
            bus_a.InValid  = (idx < 8);
            bus_a.In1      = 32'(idx);
            bus_a.In2      = 32'(idx);
            bus_a.Sub      = 1'b0;
            bus_a.Cin      = 1'b0;
            bus_a.OutReady = !(cyc >= 5 && cyc <= 8);
            cycle_a();
            if (acc_a) idx++;
        end
        bus_a.InValid  = 1'b0;
        bus_a.OutReady = 1'b1;
        check_eq("b2b_sent", idx, 8);
        check_eq("b2b_delivered", delivered_a, 8);
        check_eq("b2b_drain", sb_a.size(), 0);

        // Three in flight, then reset; an op presented on the reset edge must also vanish
        for (int i = 0; i < 3; i++) begin
            bus_a.InValid = 1'b1;
            bus_a.In1     = 32'(100 + i);
            bus_a.In2     = 32'(7 * i);
            bus_a.Sub     = 1'b0;
            bus_a.Cin     = 1'b0;
            cycle_a();
            check_eq("rst_fill_accept", acc_a, 1);
        end
        sb_a.delete();
        rst_n     = 1'b0;
        bus_a.In1 = 32'h0000_1234;
        cycle_a();
        rst_n         = 1'b1;
        bus_a.InValid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check_eq("rst_flush", bus_a.OutValid, 0);
            cycle_a();
        end
        run_iso(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b1);

        // WIDTH=8, STAGES=1 random sweep
        sent_b = 0;
        for (int cyc = 0; cyc < 3000 && sent_b < 1000; cyc++) begin
            bus_b.InValid = ($urandom_range(0, 4) != 0);
            bus_b.In1     = 8'($urandom);
            bus_b.In2     = 8'($urandom);
            bus_b.Sub     = 1'($urandom);
            bus_b.Cin     = 1'($urandom);
            cycle_b();
            if (acc_b) sent_b++;
        end
        bus_b.InValid = 1'b0;
        cycle_b();
        cycle_b();
        check_eq("b_sent", sent_b, 1000);
        check_eq("b_drain", sb_b.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
